ex_mem_stage: RTL

//  EX->MEM boundary of the pipelined RV32I core. Registers the execute result
//  for the memory stage and resolves control flow from the ALU branch flag.

---
 rtl/core_pkg.sv | 28 ++
 rtl/ex_mem_stage_if.sv | 55 +++++
 rtl/ctrl_perf_counter.sv | 18 +
 rtl/ex_mem_stage.sv | 97 +++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: datapath width, ALU class codes and
// load/store funct3 encodings used across pipeline stages.
package core_pkg;

    localparam int XLEN = 32;

    typedef enum logic [2:0] {
        RTypeALU      = 3'd0,
        ITypeALU      = 3'd1,
        LoadStoreALU  = 3'd2,
        BTypeALU      = 3'd3,
        JTypeALU      = 3'd4,
        ITypeJALR_ALU = 3'd5,
        LuiALU        = 3'd6,
        AuipcALU      = 3'd7
    } alu_class_e;

    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_jump_class(input logic [2:0] ac);
        return (ac == JTypeALU) || (ac == ITypeJALR_ALU);
    endfunction

endpackage

// File: rtl/ex_mem_stage_if.sv
// EX->MEM boundary bundle: execute-side inputs, MEM-side registered outputs,
// fetch redirect/exception pulses and perf counters.
interface ex_mem_stage_if #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 32
);
    logic             exValid;
    logic [XLEN-1:0]  exPc;
    logic [XLEN-1:0]  exImm;
    logic [XLEN-1:0]  exStoreData;
    logic [4:0]       exRd;
    logic             exRegWrite;
    logic             exMemRead;
    logic             exMemWrite;
    logic [2:0]       exFunct3;
    logic             exIsBranch;
    logic [2:0]       exAluControl;
    logic [XLEN-1:0]  aluOutput;
    logic             branch;
    logic             memStall;

    logic             memValid;
    logic [XLEN-1:0]  memResult;
    logic [XLEN-1:0]  memStoreData;
    logic [4:0]       memRd;
    logic             memRegWrite;
    logic             memMemRead;
    logic             memMemWrite;
    logic [2:0]       memFunct3;
    logic             redirect;
    logic [XLEN-1:0]  redirectPc;
    logic             excMisaligned;
    logic [XLEN-1:0]  excPc;
    logic [CNT_W-1:0] cntCtrl;
    logic [CNT_W-1:0] cntTaken;

    modport master (
        output exValid, exPc, exImm, exStoreData, exRd, exRegWrite, exMemRead,
               exMemWrite, exFunct3, exIsBranch, exAluControl, aluOutput, branch,
               memStall,
        input  memValid, memResult, memStoreData, memRd, memRegWrite, memMemRead,
               memMemWrite, memFunct3, redirect, redirectPc, excMisaligned, excPc,
               cntCtrl, cntTaken
    );

    modport slave (
        input  exValid, exPc, exImm, exStoreData, exRd, exRegWrite, exMemRead,
               exMemWrite, exFunct3, exIsBranch, exAluControl, aluOutput, branch,
               memStall,
        output memValid, memResult, memStoreData, memRd, memRegWrite, memMemRead,
               memMemWrite, memFunct3, redirect, redirectPc, excMisaligned, excPc,
               cntCtrl, cntTaken
    );

endinterface

// File: rtl/ctrl_perf_counter.sv
// Enable-increment event counter; wraps silently modulo 2^CNT_W.
module ctrl_perf_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic [CNT_W-1:0] count
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            count <= '0;
        else if (en)
            count <= count + CNT_W'(1);
    end

endmodule

// File: rtl/ex_mem_stage.sv
// EX->MEM pipeline register with control-flow resolution: registered
// redirect / misaligned-target pulses, wrong-path squash and perf counters.
module ex_mem_stage #(
    parameter int XLEN  = core_pkg::XLEN,
    parameter int CNT_W = 32
) (
    input logic           clk,
    input logic           rst_n,
    ex_mem_stage_if.slave bus
);
    import core_pkg::*;

    logic            accept, is_jump, is_ctrl, taken, misaligned;
    logic [XLEN-1:0] target, link_pc;

    logic            squash, redirect_q, exc_q;
    logic [XLEN-1:0] redirect_pc_q, exc_pc_q;
    logic            mem_valid_q, mem_rw_q, mem_mr_q, mem_mw_q;
    logic [XLEN-1:0] mem_result_q, mem_sd_q;
    logic [4:0]      mem_rd_q;
    logic [2:0]      mem_f3_q;

    assign accept     = bus.exValid & ~bus.memStall & ~squash;
    assign is_jump    = is_jump_class(bus.exAluControl);
    assign is_ctrl    = is_jump | bus.exIsBranch;
    assign taken      = accept & bus.branch & is_ctrl;
    assign target     = (bus.exAluControl == ITypeJALR_ALU) ? (bus.aluOutput & ~XLEN'(1))
                                                            : (bus.exPc + bus.exImm);
    assign misaligned = taken & target[1];
    assign link_pc    = bus.exPc + XLEN'(4);

    // A stall freezes everything, including a pending redirect/exception,
    // so the pulse is shown exactly once on the first non-stall cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            squash        <= 1'b0;
            redirect_q    <= 1'b0;
            exc_q         <= 1'b0;
            redirect_pc_q <= '0;
            exc_pc_q      <= '0;
            mem_valid_q   <= 1'b0;
            mem_rw_q      <= 1'b0;
            mem_mr_q      <= 1'b0;
            mem_mw_q      <= 1'b0;
            mem_result_q  <= '0;
            mem_sd_q      <= '0;
            mem_rd_q      <= '0;
            mem_f3_q      <= '0;
        end else if (!bus.memStall) begin
            squash      <= taken;
            redirect_q  <= taken & ~misaligned;
            exc_q       <= misaligned;
            mem_valid_q <= accept;
            if (taken & ~misaligned)
                redirect_pc_q <= target;
            if (misaligned)
                exc_pc_q <= bus.exPc;
            if (accept) begin
                mem_result_q <= is_jump ? link_pc : bus.aluOutput;
                mem_sd_q     <= bus.exStoreData;
                mem_rd_q     <= bus.exRd;
                mem_f3_q     <= bus.exFunct3;
                mem_rw_q     <= bus.exRegWrite & ~misaligned;
                mem_mr_q     <= bus.exMemRead  & ~misaligned;
                mem_mw_q     <= bus.exMemWrite & ~misaligned;
            end
        end
    end

    assign bus.memValid      = mem_valid_q;
    assign bus.memResult     = mem_result_q;
    assign bus.memStoreData  = mem_sd_q;
    assign bus.memRd         = mem_rd_q;
    assign bus.memRegWrite   = mem_rw_q;
    assign bus.memMemRead    = mem_mr_q;
    assign bus.memMemWrite   = mem_mw_q;
    assign bus.memFunct3     = mem_f3_q;
    assign bus.redirect      = redirect_q & ~bus.memStall;
    assign bus.redirectPc    = redirect_pc_q;
    assign bus.excMisaligned = exc_q & ~bus.memStall;
    assign bus.excPc         = exc_pc_q;

    ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_ctrl (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (accept & is_ctrl),
        .count (bus.cntCtrl)
    );

    ctrl_perf_counter #(.CNT_W(CNT_W)) u_cnt_taken (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (taken),
        .count (bus.cntTaken)
    );

endmodule
